// File: rtl/regfile_arb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_arb_pkg
//
// Purpose: constants shared by the register-file port arbiter and its
//          round-robin helper.
//   * FSM state encoding (IDLE / ACCESS)
//   * requester identifiers (core = 0, debug = 1). These are also the bit
//     positions inside the internal two-bit request/grant vectors, and the
//     value held by the round-robin pointer.
//   * address of the hard-wired zero register R0
// -----------------------------------------------------------------------------
package regfile_arb_pkg;

    // FSM encoding
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    // Requester identifiers / vector bit positions
    localparam int unsigned REQ_C = 0;
    localparam int unsigned REQ_D = 1;
    localparam int unsigned NUM_REQ = 2;

    // R0 always reads as zero and is never written
    localparam int unsigned R0_ADDR = 0;

endpackage : regfile_arb_pkg

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
//
// Purpose: two-way round-robin pick with a per-requester mask.
//   A requester is eligible when its request is high and its mask bit is low.
//   With one eligible requester it wins outright and the pointer is left
//   alone. With both eligible, the requester named by the pointer wins and
//   the pointer moves to the other one, so it is favoured next time.
//
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset (pointer returns to RR_INIT)
//   req_i   in   request vector, bit REQ_C / REQ_D
//   mask_i  in   requesters excluded from this pick
//   win_o   out  one-hot winner (combinational), all zero when nobody wins
// -----------------------------------------------------------------------------
module rr_arbiter2
    import regfile_arb_pkg::*;
#(
    parameter bit RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic [1:0] mask_i,
    output logic [1:0] win_o
);

    logic [1:0] elig;
    logic       ptr_q;
    logic       ptr_d;

    assign elig = req_i & ~mask_i;

    always_comb begin
        win_o = 2'b00;
        ptr_d = ptr_q;
        case (elig)
            2'b01: win_o[REQ_C] = 1'b1;
            2'b10: win_o[REQ_D] = 1'b1;
            2'b11: begin
                // Tie: the favoured side wins and hands priority over
                win_o[ptr_q] = 1'b1;
                ptr_d        = ~ptr_q;
            end
            default: win_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= RR_INIT;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arbiter2

// File: rtl/regfile_port_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_port_arbiter
//
// Purpose: shares the register file's write port and busA read port between
//   the CPU core (c_*) and the debug/scan unit (d_*). Each side raises req
//   with we/addr/wdata; a request sampled at edge N produces a one-cycle gnt
//   in cycle N+1, during which Ra/Rw/busW carry the winner's access and
//   Write is raised for writes to non-zero registers. For reads, busA is
//   captured at the end of the grant cycle and returned with x_rvalid in
//   cycle N+2; x_rdata then holds until that side's next read.
//   The side granted in the current cycle is masked from the next pick, so
//   a lone requester gets every other cycle while two requesters alternate
//   and keep the port busy every cycle.
//
// Ports:
//   Clock              in   system clock, rising edge
//   Reset_n            in   asynchronous active-low reset
//   c_req/d_req        in   access request
//   c_we/d_we          in   1 = write, 0 = read
//   c_addr/d_addr      in   register address (AW bits)
//   c_wdata/d_wdata    in   write data (DW bits)
//   c_gnt/d_gnt        out  grant, one-cycle pulse
//   c_rvalid/d_rvalid  out  read data valid, one-cycle pulse
//   c_rdata/d_rdata    out  read data, held until the next read
//   Ra                 out  RegFile read address A
//   busA               in   RegFile read data A (combinational from Ra)
//   Rw                 out  RegFile write address
//   busW               out  RegFile write data
//   Write              out  RegFile write enable
// -----------------------------------------------------------------------------
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int AW      = 5,
    parameter int DW      = 32,
    parameter int RR_INIT = 0
) (
    input  logic          Clock,
    input  logic          Reset_n,
    // core requester
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    // debug requester
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    // register file side
    output logic [AW-1:0] Ra,
    input  logic [DW-1:0] busA,
    output logic [AW-1:0] Rw,
    output logic [DW-1:0] busW,
    output logic          Write
);

    // -------------------------------------------------------------------------
    // Requester inputs gathered into vectors indexed by requester id
    // -------------------------------------------------------------------------
    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] we_vec;
    logic [AW-1:0]      addr_arr  [NUM_REQ];
    logic [DW-1:0]      wdata_arr [NUM_REQ];

    assign req_vec[REQ_C]   = c_req;
    assign req_vec[REQ_D]   = d_req;
    assign we_vec[REQ_C]    = c_we;
    assign we_vec[REQ_D]    = d_we;
    assign addr_arr[REQ_C]  = c_addr;
    assign addr_arr[REQ_D]  = d_addr;
    assign wdata_arr[REQ_C] = c_wdata;
    assign wdata_arr[REQ_D] = d_wdata;

    // -------------------------------------------------------------------------
    // Access-cycle registers
    // -------------------------------------------------------------------------
    logic [0:0]         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q,   gnt_d;
    logic [AW-1:0]      addr_q,  addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic               we_q,    we_d;
    logic               write_q, write_d;

    logic [NUM_REQ-1:0] win;
    logic               win_idx;
    logic               any_win;

    // The side granted in the current cycle is excluded from the next pick,
    // which is what forces a held request to be re-sampled only after gnt.
    rr_arbiter2 #(
        .RR_INIT (RR_INIT != 0)
    ) u_rr (
        .clk    (Clock),
        .rst_n  (Reset_n),
        .req_i  (req_vec),
        .mask_i (gnt_q),
        .win_o  (win)
    );

    assign any_win = |win;
    assign win_idx = win[REQ_D];

    always_comb begin
        state_d = ST_IDLE;
        gnt_d   = win;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        write_d = 1'b0;
        if (any_win) begin
            state_d = ST_ACCESS;
            addr_d  = addr_arr[win_idx];
            wdata_d = wdata_arr[win_idx];
            we_d    = we_vec[win_idx];
            // R0 is hard-wired: the grant still happens but nothing is written
            write_d = we_vec[win_idx] && (addr_arr[win_idx] != AW'(R0_ADDR));
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            write_q <= write_d;
        end
    end

    // -------------------------------------------------------------------------
    // Read return path, one capture register per requester. busA reflects Ra
    // during the grant cycle and is sampled at the edge that ends it.
    // -------------------------------------------------------------------------
    logic [NUM_REQ-1:0] rvalid_vec;
    logic [DW-1:0]      rdata_arr [NUM_REQ];
    logic               rd_is_r0;

    assign rd_is_r0 = (addr_q == AW'(R0_ADDR));

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rd
        logic          rd_hit;
        logic          rvalid_q;
        logic [DW-1:0] rdata_q;
        logic [DW-1:0] rdata_d;

        assign rd_hit = gnt_q[gi] & ~we_q;

        always_comb begin
            rdata_d = rdata_q;
            if (rd_hit) begin
                rdata_d = rd_is_r0 ? '0 : busA;
            end
        end

        always_ff @(posedge Clock or negedge Reset_n) begin
            if (!Reset_n) begin
                rvalid_q <= 1'b0;
                rdata_q  <= '0;
            end else begin
                rvalid_q <= rd_hit;
                rdata_q  <= rdata_d;
            end
        end

        assign rvalid_vec[gi] = rvalid_q;
        assign rdata_arr[gi]  = rdata_q;
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign c_gnt    = gnt_q[REQ_C];
    assign d_gnt    = gnt_q[REQ_D];
    assign c_rvalid = rvalid_vec[REQ_C];
    assign d_rvalid = rvalid_vec[REQ_D];
    assign c_rdata  = rdata_arr[REQ_C];
    assign d_rdata  = rdata_arr[REQ_D];

    // Ra and Rw both follow the granted address
    assign Ra    = addr_q;
    assign Rw    = addr_q;
    assign busW  = wdata_q;
    assign Write = write_q && (state_q == ST_ACCESS);

endmodule : regfile_port_arbiter

// File: tb/tb_regfile_port_arbiter.sv
module tb_regfile_port_arbiter;

    logic        clk;
    logic        Reset_n;
    logic        c_req, c_we, d_req, d_we;
    logic [4:0]  c_addr, d_addr;
    logic [31:0] c_wdata, d_wdata;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [31:0] c_rdata, d_rdata;
    logic [4:0]  Ra, Rw;
    logic [31:0] busA, busW;
    logic        Write;

    int checks   = 0;
    int failures = 0;

    // Register file model driven by the DUT, plus the bench's own view of
    // what the register contents should be.
    logic        rf_load;
    logic [31:0] rf     [32];
    logic [31:0] ref_rf [32];

    // Expected read data per requester, pushed when a read is issued
    logic [31:0] c_q [$];
    logic [31:0] d_q [$];

    regfile_port_arbiter dut (
        .Clock    (clk),
        .Reset_n  (Reset_n),
        .c_req    (c_req),
        .c_we     (c_we),
        .c_addr   (c_addr),
        .c_wdata  (c_wdata),
        .c_gnt    (c_gnt),
        .c_rvalid (c_rvalid),
        .c_rdata  (c_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .Ra       (Ra),
        .busA     (busA),
        .Rw       (Rw),
        .busW     (busW),
        .Write    (Write)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'hA000_0000 | 32'(i);
        end else if (Write) begin
            rf[Rw] <= busW;
        end
    end

    assign busA = rf[Ra];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Read-return scoreboard and global invariants
    always @(negedge clk) begin
        if (Reset_n && !rf_load) begin
            chk1("write_only_with_gnt", Write & ~(c_gnt | d_gnt), 1'b0);
            chk1("single_gnt", c_gnt & d_gnt, 1'b0);
            if (c_rvalid) begin
                if (c_q.size() == 0) chk1("c_rvalid_unexpected", c_rvalid, 1'b0);
                else chk32("c_rdata", c_rdata, c_q.pop_front());
            end
            if (d_rvalid) begin
                if (d_q.size() == 0) chk1("d_rvalid_unexpected", d_rvalid, 1'b0);
                else chk32("d_rdata", d_rdata, d_q.pop_front());
            end
        end
    end

    initial begin
        int ngnt;
        logic exp_d;
        Reset_n = 1'b0;
        rf_load = 1'b1;
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        for (int i = 0; i < 32; i++) ref_rf[i] = 32'hA000_0000 | 32'(i);

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        rf_load = 1'b0;
        chk1 ("rst_c_gnt",    c_gnt,    1'b0);
        chk1 ("rst_d_gnt",    d_gnt,    1'b0);
        chk1 ("rst_c_rvalid", c_rvalid, 1'b0);
        chk1 ("rst_d_rvalid", d_rvalid, 1'b0);
        chk1 ("rst_write",    Write,    1'b0);
        chk32("rst_ra",       32'(Ra),  32'h0);
        chk32("rst_rw",       32'(Rw),  32'h0);
        chk32("rst_busw",     busW,     32'h0);
        chk32("rst_c_rdata",  c_rdata,  32'h0);
        chk32("rst_d_rdata",  d_rdata,  32'h0);
        Reset_n = 1'b1;

        // ---------------- core write then read ----------------
        @(negedge clk);
        c_req = 1; c_we = 1; c_addr = 1; c_wdata = 32'h4;
        @(negedge clk);
        chk1 ("wr1_c_gnt", c_gnt, 1'b1);
        chk1 ("wr1_d_gnt", d_gnt, 1'b0);
        chk1 ("wr1_write", Write, 1'b1);
        chk32("wr1_rw",    32'(Rw), 32'h1);
        chk32("wr1_busw",  busW, 32'h4);
        ref_rf[1] = 32'h4;
        c_req = 0;
        @(negedge clk);
        chk1 ("wr1_gnt_pulse",  c_gnt, 1'b0);
        chk1 ("wr1_write_drop", Write, 1'b0);
        c_req = 1; c_we = 0; c_addr = 1;
        c_q.push_back(ref_rf[1]);
        @(negedge clk);
        chk1 ("rd1_c_gnt",    c_gnt, 1'b1);
        chk32("rd1_ra",       32'(Ra), 32'h1);
        chk1 ("rd1_write",    Write, 1'b0);
        chk1 ("rd1_early_rv", c_rvalid, 1'b0);
        c_req = 0;
        @(negedge clk);
        chk1 ("rd1_rvalid", c_rvalid, 1'b1);
        @(negedge clk);
        chk1 ("rd1_rvalid_pulse", c_rvalid, 1'b0);
        chk32("rd1_rdata_hold",   c_rdata, 32'h4);

        // ---------------- reset during the grant cycle ----------------
        c_req = 1; c_we = 1; c_addr = 3; c_wdata = 32'h11;
        @(negedge clk);
        chk1("rma_c_gnt", c_gnt, 1'b1);
        chk1("rma_write", Write, 1'b1);
        #2 Reset_n = 1'b0;
        #1;
        chk1("rma_write_async", Write, 1'b0);
        chk1("rma_gnt_async",   c_gnt, 1'b0);
        c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        @(negedge clk);
        Reset_n = 1'b1;
        chk32("rma_r3_kept", rf[3], ref_rf[3]);

        // ---------------- simultaneous requests after reset ----------------
        c_req = 1; c_we = 0; c_addr = 2;
        d_req = 1; d_we = 1; d_addr = 2; d_wdata = 32'h5;
        c_q.push_back(ref_rf[2]);            // read granted before the write
        @(negedge clk);
        chk1 ("sim_c_gnt_first", c_gnt, 1'b1);
        chk1 ("sim_d_wait",      d_gnt, 1'b0);
        chk32("sim_ra",          32'(Ra), 32'h2);
        chk1 ("sim_no_write",    Write, 1'b0);
        c_req = 0;
        @(negedge clk);
        chk1 ("sim_d_gnt",    d_gnt, 1'b1);
        chk1 ("sim_c_gnt_0",  c_gnt, 1'b0);
        chk1 ("sim_write",    Write, 1'b1);
        chk32("sim_rw",       32'(Rw), 32'h2);
        chk32("sim_busw",     busW, 32'h5);
        chk1 ("sim_c_rvalid", c_rvalid, 1'b1);
        ref_rf[2] = 32'h5;
        d_req = 0; d_we = 0;
        @(negedge clk);
        chk1("sim_idle_c", c_gnt, 1'b0);
        chk1("sim_idle_d", d_gnt, 1'b0);

        // ---------------- continuous contention, pointer now favours D ----------------
        c_req = 1; c_we = 0; c_addr = 5;
        d_req = 1; d_we = 0; d_addr = 6;
        for (int k = 0; k < 5; k++) begin
            c_q.push_back(ref_rf[5]);
            d_q.push_back(ref_rf[6]);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp_d = (k % 2 == 0);
            chk1($sformatf("cont_c_gnt[%0d]", k), c_gnt, ~exp_d);
            chk1($sformatf("cont_d_gnt[%0d]", k), d_gnt, exp_d);
        end
        c_req = 0; d_req = 0;
        repeat (2) @(negedge clk);

        // ---------------- read after write returns the new value ----------------
        d_req = 1; d_we = 0; d_addr = 2;
        d_q.push_back(ref_rf[2]);
        @(negedge clk);
        chk1("raw_d_gnt", d_gnt, 1'b1);
        d_req = 0;
        @(negedge clk);
        chk1("raw_d_rvalid", d_rvalid, 1'b1);

        // ---------------- R0 handling ----------------
        d_req = 1; d_we = 1; d_addr = 0; d_wdata = 32'hFFFF_0000;
        @(negedge clk);
        chk1("r0_wr_gnt",   d_gnt, 1'b1);
        chk1("r0_wr_write", Write, 1'b0);
        d_req = 0; d_we = 0; d_wdata = 0;
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 0;
        d_q.push_back(32'h0);
        @(negedge clk);
        chk1 ("r0_rd_gnt", d_gnt, 1'b1);
        chk32("r0_rd_ra",  32'(Ra), 32'h0);
        d_req = 0;
        @(negedge clk);
        chk1 ("r0_rd_rvalid", d_rvalid, 1'b1);
        chk32("r0_rf0_intact", rf[0], 32'hA000_0000);

        // ---------------- lone requester ----------------
        c_req = 1; c_we = 0; c_addr = 7;
        for (int k = 0; k < 3; k++) c_q.push_back(ref_rf[7]);
        ngnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk1($sformatf("lone_c_gnt[%0d]", k), c_gnt, (k % 2 == 0));
            if (c_gnt) ngnt++;
        end
        c_req = 0;
        chk32("lone_gnt_count", 32'(ngnt), 32'd3);

        // ---------------- drain ----------------
        repeat (3) @(negedge clk);
        chk32("c_q_drained", 32'(c_q.size()), 32'd0);
        chk32("d_q_drained", 32'(d_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile_port_arbiter
